// File: rtl/cmd_pkg.sv
// cmd_pkg: command id width and command id constants shared by the command
// parser, the command queue and the command-consuming units.
package cmd_pkg;

  localparam int CMD_BITS = 8;

  typedef logic [CMD_BITS-1:0] cmd_id_t;

  localparam cmd_id_t CMD_CONFIG_PWM   = cmd_id_t'(2);
  localparam cmd_id_t CMD_SET_PWM      = cmd_id_t'(3);
  localparam cmd_id_t CMD_SCHEDULE_PWM = cmd_id_t'(4);

endpackage

// File: rtl/cmd_queue_hdr_fifo.sv
// cmd_queue_hdr_fifo: synchronous FIFO of command headers {cmd, nargs, base}.
// The head entry is read combinationally so the queue presents the head
// command in the cycle after its header is pushed.
module cmd_queue_hdr_fifo
  import cmd_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int NARG_W = 4,
  parameter int PTR_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  cmd_id_t           push_cmd_i,
  input  logic [NARG_W-1:0] push_nargs_i,
  input  logic [PTR_W-1:0]  push_base_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              valid_o,
  output cmd_id_t           head_cmd_o,
  output logic [NARG_W-1:0] head_nargs_o,
  output logic [PTR_W-1:0]  head_base_o
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW:0] hptr_t;

  typedef struct packed {
    cmd_id_t           cmd;
    logic [NARG_W-1:0] nargs;
    logic [PTR_W-1:0]  base;
  } hdr_t;

  hdr_t  mem_q [DEPTH];
  hptr_t wr_ptr_q, wr_ptr_d;
  hptr_t rd_ptr_q, rd_ptr_d;
  hdr_t  head;

  // One extra pointer bit separates full from empty.
  assign valid_o = (wr_ptr_q != rd_ptr_q);
  assign full_o  = ((wr_ptr_q - rd_ptr_q) == hptr_t'(DEPTH));

  assign head         = mem_q[rd_ptr_q[AW-1:0]];
  assign head_cmd_o   = head.cmd;
  assign head_nargs_o = head.nargs;
  assign head_base_o  = head.base;

  // Next-state pointers for push and pop.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i && !full_o) wr_ptr_d = wr_ptr_q + hptr_t'(1);
    if (pop_i && valid_o)  rd_ptr_d = rd_ptr_q + hptr_t'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of block order.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Header storage write.
  // NOTE: the storage array has no reset; pointer reset alone makes its contents invisible, and an unreset array maps onto RAM.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) begin
      mem_q[wr_ptr_q[AW-1:0]] <= '{cmd: push_cmd_i, nargs: push_nargs_i, base: push_base_i};
    end
  end

endmodule

// File: rtl/cmd_queue.sv
// cmd_queue: buffers decoded host commands (id + argument words) between the
// command parser and the command-consuming units. A command becomes visible
// only once its last argument is stored; argument read is a combinational
// look-ahead so a consumer can take one argument per cycle.
// Optional build macro: CMD_QUEUE_CHECK_EN enables the sticky err output.
module cmd_queue
  import cmd_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int HDR_DEPTH = 16,
  parameter int MAX_ARGS  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         wr_data,
  input  logic [CMD_BITS-1:0] wr_cmd,
  input  logic                wr_valid,
  input  logic                wr_last,
  output logic                wr_ready,
  output logic [CMD_BITS-1:0] cmd,
  output logic                cmd_ready,
  output logic [31:0]         arg_data,
  input  logic                arg_advance,
  input  logic                cmd_done,
  output logic                err
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(MAX_ARGS + 1);

  typedef logic [AW:0]   ptr_t;
  typedef logic [NW-1:0] narg_t;

  localparam narg_t MAX_N = narg_t'(MAX_ARGS);

  logic [31:0] mem_q [DEPTH];

  // Write side state: storage pointer and the command currently being written.
  ptr_t    wr_ptr_q, wr_ptr_d;
  ptr_t    base_q, base_d;
  narg_t   cnt_q, cnt_d;
  cmd_id_t id_q, id_d;
  logic    open_q, open_d;

  // Read side state.
  ptr_t  rd_ptr_q, rd_ptr_d;
  narg_t idx_q, idx_d;

  logic    word_full, hdr_full, wr_fire, store, hdr_push, hdr_pop;
  narg_t   cnt_cur, push_nargs, nargs_eff;
  cmd_id_t push_cmd;
  ptr_t    push_base;

  logic    head_valid;
  cmd_id_t head_cmd;
  narg_t   head_nargs;
  ptr_t    head_base;

  logic [NW:0]   look;
  logic [AW-1:0] look_addr;

  // Occupancy includes uncommitted words so a long open command stalls the writer.
  assign word_full = ((wr_ptr_q - rd_ptr_q) == ptr_t'(DEPTH));
  assign wr_ready  = rst_n && !word_full && (open_q || !hdr_full);
  assign wr_fire   = wr_valid && wr_ready;
  assign hdr_push  = wr_fire && wr_last;
  assign hdr_pop   = cmd_done && head_valid;

  // Write-side next state: store up to MAX_ARGS words, drop the rest, commit on wr_last.
  always_comb begin
    cnt_cur    = open_q ? cnt_q : '0;
    store      = (cnt_cur < MAX_N);
    push_cmd   = open_q ? id_q : wr_cmd;
    push_base  = open_q ? base_q : wr_ptr_q;
    push_nargs = cnt_cur + narg_t'(store);
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    base_d     = base_q;
    open_d     = open_q;
    if (wr_fire) begin
      if (store) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      cnt_d  = push_nargs;
      id_d   = push_cmd;
      base_d = push_base;
      open_d = !wr_last;
    end
  end

  // Write-side registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      base_q   <= '0;
      cnt_q    <= '0;
      id_q     <= '0;
      open_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      id_q     <= id_d;
      open_q   <= open_d;
    end
  end

  // Argument storage write (LUT RAM, combinational read below).
  always_ff @(posedge clk) begin
    if (wr_fire && store) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  // The header push on wr_last is what publishes the command to the read side.
  cmd_queue_hdr_fifo #(
    .DEPTH  (HDR_DEPTH),
    .NARG_W (NW),
    .PTR_W  (AW + 1)
  ) u_hdr_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (hdr_push),
    .push_cmd_i   (push_cmd),
    .push_nargs_i (push_nargs),
    .push_base_i  (push_base),
    .pop_i        (hdr_pop),
    .full_o       (hdr_full),
    .valid_o      (head_valid),
    .head_cmd_o   (head_cmd),
    .head_nargs_o (head_nargs),
    .head_base_o  (head_base)
  );

  // Read-side next state: cmd_done frees the whole head command and wins over advance.
  always_comb begin
    nargs_eff = head_valid ? head_nargs : '0;
    rd_ptr_d  = rd_ptr_q;
    idx_d     = idx_q;
    if (hdr_pop) begin
      rd_ptr_d = head_base + ptr_t'(head_nargs);
      idx_d    = '0;
    end else if (arg_advance && (idx_q < nargs_eff)) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
      idx_d    = idx_q + narg_t'(1);
    end
  end

  // Read-side registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      idx_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      idx_q    <= idx_d;
    end
  end

  // Look-ahead: with arg_advance high the consumer already sees the next argument.
  assign look      = {1'b0, idx_q} + {{NW{1'b0}}, arg_advance};
  assign look_addr = rd_ptr_q[AW-1:0] + AW'(arg_advance);
  assign arg_data  = (look < {1'b0, nargs_eff}) ? mem_q[look_addr] : '0;
  assign cmd       = head_valid ? head_cmd : '0;
  assign cmd_ready = head_valid && !cmd_done;

`ifdef CMD_QUEUE_CHECK_EN
  logic err_q, err_d;

  // Sticky error: over-advance, cmd_done without a head, or a truncated write.
  always_comb begin
    err_d = err_q;
    if ((arg_advance && (idx_q >= nargs_eff)) ||
        (cmd_done && !head_valid) ||
        (wr_fire && !store)) begin
      err_d = 1'b1;
    end
  end

  // Error register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_queue.sv
// tb_cmd_queue: scoreboard bench for cmd_queue. The writer pushes committed
// commands into a reference queue; a monitor compares the unit-side outputs
// against that queue every cycle and pops on cmd_done.
`timescale 1ns/1ps
module tb_cmd_queue;
  import cmd_pkg::*;

  localparam int DEPTH     = 64;
  localparam int HDR_DEPTH = 16;
  localparam int MAX_ARGS  = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [31:0]         wr_data;
  logic [CMD_BITS-1:0] wr_cmd;
  logic                wr_valid;
  logic                wr_last;
  logic                wr_ready;
  logic [CMD_BITS-1:0] cmd;
  logic                cmd_ready;
  logic [31:0]         arg_data;
  logic                arg_advance;
  logic                cmd_done;
  logic                err;

  cmd_queue #(
    .DEPTH     (DEPTH),
    .HDR_DEPTH (HDR_DEPTH),
    .MAX_ARGS  (MAX_ARGS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_data     (wr_data),
    .wr_cmd      (wr_cmd),
    .wr_valid    (wr_valid),
    .wr_last     (wr_last),
    .wr_ready    (wr_ready),
    .cmd         (cmd),
    .cmd_ready   (cmd_ready),
    .arg_data    (arg_data),
    .arg_advance (arg_advance),
    .cmd_done    (cmd_done),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic        last;
  } beat_t;

  // Pending writer beats.
  beat_t beat_q[$];

  // Reference model: committed commands in order, their stored args flattened.
  logic [7:0]  exp_id[$];
  int          exp_n[$];
  logic [31:0] args_q[$];
  logic [31:0] open_args[$];
  logic [7:0]  open_id;
  bit          open;
  int          k;
  bit          exp_err;

  int n_pass;
  int n_total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_beat(input logic [7:0] id, input logic [31:0] d, input bit last);
    beat_t b;
    b.id   = id;
    b.data = d;
    b.last = last;
    beat_q.push_back(b);
  endtask

  task automatic add_rand_cmd(input logic [7:0] id, input int nb);
    for (int i = 0; i < nb; i++) push_beat(id, $urandom, (i == nb - 1));
  endtask

  // A beat was accepted at the last edge: record it in the model.
  task automatic accept_beat();
    beat_t b;
    b = beat_q.pop_front();
    if (!open) begin
      open    = 1'b1;
      open_id = b.id;
      open_args.delete();
    end
    if (open_args.size() < MAX_ARGS) open_args.push_back(b.data);
`ifdef CMD_QUEUE_CHECK_EN
    else exp_err = 1'b1;
`endif
    if (b.last) begin
      exp_id.push_back(open_id);
      exp_n.push_back(open_args.size());
      foreach (open_args[i]) args_q.push_back(open_args[i]);
      open_args.delete();
      open = 1'b0;
    end
  endtask

  // One clock: drive just after posedge, sample handshake at negedge.
  task automatic cycle(input bit wen, input bit adv, input bit done);
    bit acc;
    if (wen && beat_q.size() > 0) begin
      wr_valid = 1'b1;
      wr_cmd   = beat_q[0].id;
      wr_data  = beat_q[0].data;
      wr_last  = beat_q[0].last;
    end else begin
      wr_valid = 1'b0;
      wr_cmd   = 8'($urandom);
      wr_data  = $urandom;
      wr_last  = 1'($urandom);
    end
    arg_advance = adv;
    cmd_done    = done;
    @(negedge clk);
    acc = wr_valid && wr_ready;
    @(posedge clk);
    #1;
    if (acc) accept_beat();
  endtask

  task automatic run(input int n, input bit wen, input bit adv, input bit done);
    repeat (n) cycle(wen, adv, done);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    beat_q.delete();
    open_args.delete();
    exp_id.delete();
    exp_n.delete();
    args_q.delete();
    open    = 1'b0;
    k       = 0;
    exp_err = 1'b0;
    run(n, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  // Monitor: compare outputs against the model, then apply the read-side edge.
  initial begin : monitor
    bit          have;
    int          n;
    int          la;
    int          occ;
    logic [31:0] e_arg;
    logic [7:0]  e_cmd;
    bit          e_wr;
    forever begin
      @(negedge clk);
      have  = (exp_id.size() > 0);
      n     = have ? exp_n[0] : 0;
      e_cmd = have ? exp_id[0] : 8'h00;
      la    = k + int'(arg_advance);
      e_arg = (have && la < n) ? args_q[la] : 32'h0;
      occ   = args_q.size() - k + open_args.size();
      e_wr  = rst_n && (occ < DEPTH) && (open || exp_id.size() < HDR_DEPTH);
      check("cmd_ready", 32'(cmd_ready), 32'(have && !cmd_done));
      check("cmd", 32'(cmd), 32'(e_cmd));
      check("arg_data", arg_data, e_arg);
      check("wr_ready", 32'(wr_ready), 32'(e_wr));
      check("err", 32'(err), 32'(exp_err));
      if (rst_n) begin
`ifdef CMD_QUEUE_CHECK_EN
        if ((arg_advance && k >= n) || (cmd_done && !have)) exp_err = 1'b1;
`endif
        if (cmd_done && have) begin
          repeat (n) void'(args_q.pop_front());
          void'(exp_id.pop_front());
          void'(exp_n.pop_front());
          k = 0;
        end else if (arg_advance && k < n) begin
          k++;
        end
      end
    end
  end

  initial begin : stimulus
    n_pass      = 0;
    n_total     = 0;
    open        = 1'b0;
    k           = 0;
    exp_err     = 1'b0;
    rst_n       = 1'b1;
    wr_valid    = 1'b0;
    wr_data     = '0;
    wr_cmd      = '0;
    wr_last     = 1'b0;
    arg_advance = 1'b0;
    cmd_done    = 1'b0;
    @(posedge clk);
    #1;
    do_reset(3);

    // Streaming consumer: 5, 1000, 300, 1, 50000, then 0; done drops cmd_ready.
    push_beat(CMD_CONFIG_PWM, 32'd5,     1'b0);
    push_beat(CMD_CONFIG_PWM, 32'd1000,  1'b0);
    push_beat(CMD_CONFIG_PWM, 32'd300,   1'b0);
    push_beat(CMD_CONFIG_PWM, 32'd1,     1'b0);
    push_beat(CMD_CONFIG_PWM, 32'd50000, 1'b1);
    run(5, 1'b1, 1'b0, 1'b0);
    run(1, 1'b0, 1'b0, 1'b0);
    run(5, 1'b0, 1'b1, 1'b0);
    run(1, 1'b0, 1'b0, 1'b1);
    run(1, 1'b0, 1'b0, 1'b0);

    // Early cmd_done frees the skipped word 7; cmd 4 shows up next cycle.
    push_beat(CMD_SET_PWM, 32'd1, 1'b0);
    push_beat(CMD_SET_PWM, 32'd7, 1'b1);
    push_beat(CMD_SCHEDULE_PWM, 32'd2, 1'b1);
    run(3, 1'b1, 1'b0, 1'b0);
    run(1, 1'b0, 1'b1, 1'b0);
    run(1, 1'b0, 1'b0, 1'b1);
    run(1, 1'b0, 1'b0, 1'b0);
    run(1, 1'b0, 1'b0, 1'b1);

    // Open command stays invisible; 11 beats truncate to MAX_ARGS.
    add_rand_cmd(8'h55, 11);
    run(6, 1'b1, 1'b0, 1'b0);
    run(5, 1'b1, 1'b0, 1'b0);
    run(1, 1'b0, 1'b0, 1'b0);
    run(MAX_ARGS, 1'b0, 1'b1, 1'b0);
    run(1, 1'b0, 1'b0, 1'b1);

    // Word storage full: writer stalls, then drains.
    for (int c = 0; c < DEPTH / MAX_ARGS; c++) add_rand_cmd(8'(c + 16), MAX_ARGS);
    add_rand_cmd(8'hA5, 1);
    run(DEPTH + 6, 1'b1, 1'b0, 1'b0);
    run(12, 1'b1, 1'b0, 1'b1);
    run(2, 1'b0, 1'b0, 1'b0);

    // Header storage full; advance and done together (done wins).
    for (int c = 0; c < HDR_DEPTH + 1; c++) add_rand_cmd(8'(c + 64), 1);
    run(HDR_DEPTH + 4, 1'b1, 1'b0, 1'b0);
    run(HDR_DEPTH + 4, 1'b1, 1'b1, 1'b1);

    // Commit on wr_last in the same cycle as cmd_done, pointers past the wrap.
    add_rand_cmd(8'h21, 2);
    run(2, 1'b1, 1'b0, 1'b0);
    add_rand_cmd(8'h22, 3);
    run(2, 1'b1, 1'b0, 1'b0);
    run(1, 1'b1, 1'b0, 1'b1);
    run(1, 1'b0, 1'b0, 1'b0);
    run(3, 1'b0, 1'b1, 1'b0);
    run(1, 1'b0, 1'b0, 1'b1);

    // Reset mid-read and mid-write, then a clean command.
    add_rand_cmd(8'h31, 3);
    run(3, 1'b1, 1'b0, 1'b0);
    add_rand_cmd(8'h32, 6);
    run(3, 1'b1, 1'b1, 1'b0);
    do_reset(2);
    push_beat(CMD_SET_PWM, 32'h1234, 1'b0);
    push_beat(CMD_SET_PWM, 32'hABCD, 1'b1);
    run(2, 1'b1, 1'b0, 1'b0);
    run(2, 1'b0, 1'b1, 1'b0);
    run(1, 1'b0, 1'b0, 1'b1);

    // Advance past nargs=1: err sticky only in the checking build.
    push_beat(8'h40, 32'h77, 1'b1);
    run(1, 1'b1, 1'b0, 1'b0);
    run(1, 1'b0, 1'b0, 1'b0);
    run(3, 1'b0, 1'b1, 1'b0);
    run(1, 1'b0, 1'b0, 1'b1);
    run(2, 1'b0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (beat_q.size() < 4) add_rand_cmd(8'($urandom), int'($urandom_range(1, 11)));
      cycle(($urandom % 4) != 0, 1'($urandom), ($urandom % 5) == 0);
    end
    run(200, 1'b1, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
